// File: rtl/mux_4x1.sv
// Registered 4-to-1 single-bit multiplexer.
// Picks data[sel] and presents it on a flop one clock later, so downstream
// logic sees a glitch-free, timing-isolated bit with no combinational path
// from the inputs.
module mux_4x1 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] data,
  input  logic [1:0] sel,
  output logic       out
);

  logic next_bit;

  // Lane selection; an unknown select falls to the default arm and loads 0
  // rather than forwarding X, while X on the chosen lane still passes through.
  always_comb begin
    next_bit = 1'b0;
    case (sel)
      2'b00:   next_bit = data[0];
      2'b01:   next_bit = data[1];
      2'b10:   next_bit = data[2];
      2'b11:   next_bit = data[3];
      default: next_bit = 1'b0;
    endcase
  end

  // Output flop: async reset clears it at once, otherwise load every edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= 1'b0;
    end else begin
      out <= next_bit;
    end
  end

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1: directed test-plan cases plus random
// stimulus compared against an arithmetic model of data[sel].
module tb_mux_4x1;

  logic       clk;
  logic       rst;
  logic [3:0] data;
  logic [1:0] sel;
  logic       out;

  int total = 0;
  int bad   = 0;

  mux_4x1 dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .sel  (sel),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: lane s of d, taken as the s-th binary digit of d.
  function automatic logic ref_bit(input int d, input int s);
    return logic'((d / (1 << s)) % 2);
  endfunction

  task automatic check(input string tag, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b expected=%b at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one combination, clock it through, check one cycle later.
  task automatic apply(input logic [3:0] d, input logic [1:0] s, input string tag);
    logic exp;
    data = d;
    sel  = s;
    exp  = ref_bit(int'(d), int'(s));
    @(posedge clk);
    #1;
    check(tag, out, exp);
  endtask

  logic [1:0] sel_unknown;
  logic [3:0] rd;
  logic [1:0] rs;

  initial begin
    // Reset held for two cycles with all-ones data on lane 3
    rst  = 1'b1;
    data = 4'b1111;
    sel  = 2'b11;
    #1;
    check("reset_immediate", out, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
      check("reset_hold", out, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset_release", out, 1'b1);

    // Single-hot sweep on lane 3
    for (int s = 0; s < 4; s++) begin
      apply(4'b1000, 2'(s), "onehot_sweep");
    end

    // Exhaustive 16 x 4
    for (int d = 0; d < 16; d++) begin
      for (int s = 0; s < 4; s++) begin
        apply(4'(d), 2'(s), "exhaustive");
      end
    end

    // Glitch immunity: select toggles between edges must not reach out
    apply(4'b0101, 2'b00, "glitch_setup");
    #2 sel = 2'b01;
    #1;
    check("glitch_mid_toggle", out, 1'b1);
    #1 sel = 2'b00;
    @(posedge clk);
    #1;
    check("glitch_after_edge", out, 1'b1);
    apply(4'b0101, 2'b01, "glitch_final_sel");

    // Async reset pulse between edges
    apply(4'b0101, 2'b00, "async_setup");
    #1 rst = 1'b1;
    #1;
    check("async_drop", out, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("async_hold_no_edge", out, 1'b0);
    @(posedge clk);
    #1;
    check("async_resume", out, 1'b1);

    // Unknown select loads 0; only meaningful where the simulator keeps X
    sel_unknown = 2'bx1;
    if ($isunknown(sel_unknown)) begin
      data = 4'b1111;
      sel  = sel_unknown;
      @(posedge clk);
      #1;
      check("unknown_sel", out, 1'b0);
    end

    // Randomized stimulus against the reference model
    for (int i = 0; i < 200; i++) begin
      rd = 4'($urandom_range(15, 0));
      rs = 2'($urandom_range(3, 0));
      apply(rd, rs, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always terminates
  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
